// File: rtl/cal_factor_seq_pkg.sv
// Shared definitions for the calibration-factor sequencer: FSM encoding,
// channel count, coefficient format and coefficient RAM address map.
package cal_factor_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_GAIN,
        RD_OFS,
        WAIT_SMP,
        MUL,
        ADD,
        OUT,
        FIN
    } state_t;

    localparam int NUM_CH_DEF  = 6;
    localparam int GAIN_FRAC_W = 15;
    localparam int IDX_W       = 3;
    localparam int ADDR_W      = 4;
    localparam int SMP_W       = 16;
    localparam int GAIN_W      = 16;
    localparam int RES_W       = 32;

    // Each index owns two consecutive RAM words: gain first, offset second.
    function automatic logic [ADDR_W-1:0] gain_addr(input logic [IDX_W-1:0] idx);
        return {idx, 1'b0};
    endfunction

    function automatic logic [ADDR_W-1:0] ofs_addr(input logic [IDX_W-1:0] idx);
        return {idx, 1'b1};
    endfunction

endpackage

// File: rtl/cal_mac_sat.sv
// Two-stage calibration datapath: registered gain x sample product, then
// Q1.15 rescale, offset add and saturation into the result register.
module cal_mac_sat
    import cal_factor_seq_pkg::*;
#(
    parameter int DATA_W = SMP_W,
    parameter int COEF_W = GAIN_W
) (
    input  logic                     clk_sys,
    input  logic                     rst_sys_n,
    input  logic                     mul_en,
    input  logic                     clr,
    input  logic signed [COEF_W-1:0] gain,
    input  logic signed [DATA_W-1:0] sample,
    input  logic signed [RES_W-1:0]  offset,
    output logic signed [RES_W-1:0]  result
);

    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] prod_p0;
    logic                     vld_p0;
    logic signed [RES_W-1:0]  res_p1;

    function automatic logic signed [RES_W-1:0] sat_add(
        input logic signed [PROD_W-1:0] prod,
        input logic signed [RES_W-1:0]  ofs
    );
        logic signed [PROD_W-1:0] shf;
        logic signed [RES_W:0]    sum;
        shf = prod >>> GAIN_FRAC_W;
        sum = {{(RES_W + 1 - PROD_W){shf[PROD_W-1]}}, shf} + {ofs[RES_W-1], ofs};
        if (sum[RES_W] != sum[RES_W-1]) begin
            return sum[RES_W] ? {1'b1, {(RES_W-1){1'b0}}} : {1'b0, {(RES_W-1){1'b1}}};
        end
        return sum[RES_W-1:0];
    endfunction

    // Stage p0: product
    always_ff @(posedge clk_sys) begin
        if (mul_en) begin
            prod_p0 <= gain * sample;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= mul_en;
        end
    end

    // Stage p1: rescale, offset, saturate; a timed-out index forces zero
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            res_p1 <= '0;
        end else if (clr) begin
            res_p1 <= '0;
        end else if (vld_p0) begin
            res_p1 <= sat_add(prod_p0, offset);
        end
    end

    assign result = res_p1;

endmodule

// File: rtl/cal_factor_seq.sv
// Calibration-factor sequencer: per index reads gain/offset, fetches one raw
// sample, calibrates it and writes the result to the six-register bank.
module cal_factor_seq
    import cal_factor_seq_pkg::*;
#(
    parameter int TMO_CYC = 255,
    parameter int NUM_CH  = NUM_CH_DEF
) (
    input  logic              clk_sys,
    input  logic              rst_sys_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [5:0]        err_ch,
    output logic              coef_rd_en,
    output logic [ADDR_W-1:0] coef_addr,
    input  logic [31:0]       coef_rd_data,
    output logic              smp_req,
    output logic [IDX_W-1:0]  smp_sel,
    input  logic              smp_vld,
    input  logic [SMP_W-1:0]  smp_data,
    output logic              data_en,
    output logic [IDX_W-1:0]  data_sel,
    output logic [RES_W-1:0]  data_in
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
    localparam logic [7:0]       TMO_LAST = 8'(TMO_CYC - 1);

    state_t                    state, state_nxt;
    logic [IDX_W-1:0]          idx, idx_nxt;
    logic [7:0]                tmo_cnt;
    logic                      accept;
    logic                      timeout;

    logic signed [GAIN_W-1:0]  gain_p0;
    logic signed [RES_W-1:0]   ofs_p0;
    logic signed [SMP_W-1:0]   smp_p0;
    logic signed [RES_W-1:0]   result;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        accept    = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RD_GAIN;
                    idx_nxt   = '0;
                end
            end
            RD_GAIN:  state_nxt = RD_OFS;
            RD_OFS:   state_nxt = WAIT_SMP;
            WAIT_SMP: begin
                if (smp_vld) begin
                    accept    = 1'b1;
                    state_nxt = MUL;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = OUT;
                end
            end
            MUL:      state_nxt = ADD;
            ADD:      state_nxt = OUT;
            OUT: begin
                if (idx == LAST_IDX) begin
                    state_nxt = FIN;
                end else begin
                    idx_nxt   = idx + 1'b1;
                    state_nxt = RD_GAIN;
                end
            end
            FIN:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state   <= IDLE;
            idx     <= '0;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            tmo_cnt <= (state == WAIT_SMP && state_nxt == WAIT_SMP) ? tmo_cnt + 1'b1 : '0;
        end
    end

    // Outputs are decoded from the next state so each one is a flop.
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            err_ch     <= '0;
            coef_rd_en <= 1'b0;
            coef_addr  <= '0;
            smp_req    <= 1'b0;
            smp_sel    <= '0;
            data_en    <= 1'b0;
            data_sel   <= '0;
        end else begin
            busy       <= (state_nxt != IDLE);
            done       <= (state_nxt == FIN);
            coef_rd_en <= (state_nxt == RD_GAIN) || (state_nxt == RD_OFS);
            smp_req    <= (state_nxt == WAIT_SMP);
            data_en    <= (state_nxt == OUT);
            if (state_nxt == RD_GAIN) begin
                coef_addr <= gain_addr(idx_nxt);
            end else if (state_nxt == RD_OFS) begin
                coef_addr <= ofs_addr(idx_nxt);
            end
            if (state_nxt == WAIT_SMP) begin
                smp_sel <= idx_nxt;
            end
            if (state_nxt == OUT) begin
                data_sel <= idx_nxt;
            end
            if (state == IDLE && start) begin
                err_ch <= '0;
            end else if (timeout) begin
                err_ch[idx] <= 1'b1;
            end
        end
    end

    // Operand capture: RAM data lags its read strobe by one cycle
    always_ff @(posedge clk_sys) begin
        if (state == RD_OFS) begin
            gain_p0 <= coef_rd_data[GAIN_W-1:0];
        end
        if (state == WAIT_SMP && tmo_cnt == '0) begin
            ofs_p0 <= coef_rd_data;
        end
        if (accept) begin
            smp_p0 <= smp_data;
        end
    end

    cal_mac_sat #(
        .DATA_W (SMP_W),
        .COEF_W (GAIN_W)
    ) u_mac (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .mul_en    (state == MUL),
        .clr       (timeout),
        .gain      (gain_p0),
        .sample    (smp_p0),
        .offset    (ofs_p0),
        .result    (result)
    );

    assign data_in = result;

endmodule
